// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_stage_pkg
// Description : Shared widths, reset PC and bus layouts for the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package if_stage_pkg;

  localparam int          FS_TO_DS_BUS_WD  = 64;
  localparam int          BR_BUS_WD        = 33;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

  // Redirect request from decode
  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } br_bus_t;

  // Instruction handed to decode
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fs_to_ds_t;

endpackage
`default_nettype wire

// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : if_stage_if
// Description : Fetch-stage bundle: decode handshake, branch bus and
//               instruction SRAM read port.
// Revision    : 1.0 - initial release
// ============================================================================
interface if_stage_if;
  import if_stage_pkg::*;

  logic                       ds_allowin;
  logic [BR_BUS_WD-1:0]       br_bus;
  logic                       fs_to_ds_valid;
  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
  logic                       inst_sram_en;
  logic [3:0]                 inst_sram_wen;
  logic [31:0]                inst_sram_addr;
  logic [31:0]                inst_sram_rdata;

  // Fetch stage side
  modport master (
    input  ds_allowin, br_bus, inst_sram_rdata,
    output fs_to_ds_valid, fs_to_ds_bus, inst_sram_en, inst_sram_wen, inst_sram_addr
  );

  // Decode / SRAM side
  modport slave (
    output ds_allowin, br_bus, inst_sram_rdata,
    input  fs_to_ds_valid, fs_to_ds_bus, inst_sram_en, inst_sram_wen, inst_sram_addr
  );

endinterface
`default_nettype wire

// File: rtl/if_stage_dff.sv
`default_nettype none
// ============================================================================
// Module      : if_stage_dff
// Description : Enable flop with asynchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage_dff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load d when enabled; reset value applied asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  q <= RST_VAL;
    else if (en) q <= d;
  end

endmodule
`default_nettype wire

// File: rtl/if_stage_inst_buf.sv
`default_nettype none
// ============================================================================
// Module      : if_stage_inst_buf
// Description : One-entry holding register for SRAM read data while decode
//               stalls; bypasses rdata straight through when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage_inst_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        fill,
  input  logic        clear,
  input  logic [31:0] rdata,
  output logic [31:0] inst,
  output logic        buf_valid
);

  logic [31:0] inst_buf;

  // Occupancy flag; a clear wins over a simultaneous fill
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     buf_valid <= 1'b0;
    else if (clear) buf_valid <= 1'b0;
    else if (fill)  buf_valid <= 1'b1;
  end

  // Capture the SRAM word on the first stall cycle only
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                inst_buf <= 32'h0;
    else if (fill && !clear)   inst_buf <= rdata;
  end

  assign inst = buf_valid ? inst_buf : rdata;

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : Instruction fetch stage: next-PC selection with delay-slot
//               aware redirect, SRAM read request, stall buffer and the
//               valid/allowin handshake towards decode.
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  if_stage_if.master fs
);

  br_bus_t     br;
  fs_to_ds_t   out_bus;
  logic        to_fs_valid, fs_valid, br_pend, buf_valid;
  logic [31:0] fs_pc, br_pend_target, nextpc, fs_inst;
  logic        fs_allowin, accept, br_set;
  logic        fs_valid_en, br_pend_en, buf_fill, buf_clear;

  assign br = br_bus_t'(fs.br_bus);

  // A new fetch is issued whenever the stage is free or drains this cycle
  assign fs_allowin = !fs_valid || fs.ds_allowin;
  assign accept     = to_fs_valid && fs_allowin;

  // A branch seen while fs is empty: the next fetch is still the delay slot,
  // so the target is parked and used by the fetch after that.
  assign br_set     = br.taken && !fs_valid && !br_pend;

  assign nextpc = br_pend                ? br_pend_target :
                  (br.taken && fs_valid) ? br.target      :
                                           fs_pc + 32'd4;

  assign fs_valid_en = accept || (fs_valid && fs.ds_allowin);
  assign br_pend_en  = br_set || accept;
  assign buf_fill    = fs_valid && !fs.ds_allowin && !buf_valid;
  assign buf_clear   = fs_valid && fs.ds_allowin;

  if_stage_dff #(.WIDTH(1), .RST_VAL(1'b0)) u_to_fs_valid (
    .clk(clk), .reset(reset), .en(1'b1), .d(1'b1), .q(to_fs_valid)
  );

  if_stage_dff #(.WIDTH(1), .RST_VAL(1'b0)) u_fs_valid (
    .clk(clk), .reset(reset), .en(fs_valid_en), .d(accept), .q(fs_valid)
  );

  if_stage_dff #(.WIDTH(32), .RST_VAL(RESET_PC - 32'd4)) u_fs_pc (
    .clk(clk), .reset(reset), .en(accept), .d(nextpc), .q(fs_pc)
  );

  if_stage_dff #(.WIDTH(1), .RST_VAL(1'b0)) u_br_pend (
    .clk(clk), .reset(reset), .en(br_pend_en), .d(br_set), .q(br_pend)
  );

  if_stage_dff #(.WIDTH(32), .RST_VAL(32'h0)) u_br_pend_target (
    .clk(clk), .reset(reset), .en(br_set), .d(br.target), .q(br_pend_target)
  );

  if_stage_inst_buf u_inst_buf (
    .clk       (clk),
    .reset     (reset),
    .fill      (buf_fill),
    .clear     (buf_clear),
    .rdata     (fs.inst_sram_rdata),
    .inst      (fs_inst),
    .buf_valid (buf_valid)
  );

  assign out_bus.pc   = fs_pc;
  assign out_bus.inst = fs_inst;

  assign fs.fs_to_ds_valid = fs_valid;
  assign fs.fs_to_ds_bus   = out_bus;
  assign fs.inst_sram_en   = accept;
  assign fs.inst_sram_wen  = 4'b0000;
  assign fs.inst_sram_addr = nextpc;

endmodule
`default_nettype wire
